// File: rtl/user_wb_initiator.sv
// user_wb_initiator: Wishbone classic single-transfer initiator for the user-area
// slave port. One-deep command/response handshake in, cyc/stb cycles out, with a
// bounded ack timeout so an unresponsive user design cannot stall the caller.
// Optional statistics counters are enabled by defining USER_WB_INIT_STATS_EN.
module user_wb_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  input  logic [3:0]  cmd_sel,
  output logic        rsp_valid,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,
  output logic        busy,
  output logic        wbs_cyc_o,
  output logic        wbs_stb_o,
  output logic        wbs_we_o,
  output logic [3:0]  wbs_sel_o,
  output logic [31:0] wbs_adr_o,
  output logic [31:0] wbs_dat_o,
  input  logic        wbs_ack_i,
  input  logic [31:0] wbs_dat_i
`ifdef USER_WB_INIT_STATS_EN
  ,
  output logic [15:0] txn_count,
  output logic [7:0]  timeout_count
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

  // Counter value seen during the last permitted BUS cycle.
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_next;
  logic        r_we;
  logic [31:0] r_adr;
  logic [31:0] r_dat;
  logic [3:0]  r_sel;
  logic [15:0] r_to_cnt;
  logic [31:0] r_rsp_dat;
  logic        r_rsp_err;
  logic        w_accept;
  logic        w_ack;
  logic        w_timeout;

  assign w_accept  = (r_state == S_IDLE) && cmd_valid;
  assign w_ack     = (r_state == S_BUS) && wbs_ack_i;
  // Ack on the final permitted cycle takes priority over the timeout.
  assign w_timeout = (r_state == S_BUS) && !wbs_ack_i && (r_to_cnt == TO_LAST);

  // State register; reset abandons any cycle in flight without a response.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (cmd_valid) w_state_next = S_BUS;
      S_BUS:   if (w_ack || w_timeout) w_state_next = S_RESP;
      S_RESP:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // State-decoded outputs; stb always mirrors cyc in classic single transfers.
  always_comb begin
    cmd_ready = 1'b0;
    wbs_cyc_o = 1'b0;
    rsp_valid = 1'b0;
    busy      = 1'b1;
    case (r_state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
      end
      S_BUS:   wbs_cyc_o = 1'b1;
      S_RESP:  rsp_valid = 1'b1;
      default: busy      = 1'b0;
    endcase
    wbs_stb_o = wbs_cyc_o;
  end

  // Command capture, timeout counting and response capture.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_we      <= 1'b0;
      r_adr     <= '0;
      r_dat     <= '0;
      r_sel     <= '0;
      r_to_cnt  <= '0;
      r_rsp_dat <= '0;
      r_rsp_err <= 1'b0;
    end else begin
      if (w_accept) begin
        r_we     <= cmd_we;
        r_adr    <= cmd_adr;
        r_dat    <= cmd_we ? cmd_dat : 32'h0;
        r_sel    <= cmd_sel;
        r_to_cnt <= '0;
      end else if ((r_state == S_BUS) && !wbs_ack_i) begin
        r_to_cnt <= r_to_cnt + 16'd1;
      end
      if (w_ack) begin
        r_rsp_dat <= r_we ? 32'h0 : wbs_dat_i;
        r_rsp_err <= 1'b0;
      end else if (w_timeout) begin
        r_rsp_dat <= r_we ? 32'h0 : ERR_DATA;
        r_rsp_err <= 1'b1;
      end
    end
  end

  assign wbs_we_o  = r_we;
  assign wbs_adr_o = r_adr;
  assign wbs_dat_o = r_dat;
  assign wbs_sel_o = r_sel;
  assign rsp_dat   = r_rsp_dat;
  assign rsp_err   = r_rsp_err;

`ifdef USER_WB_INIT_STATS_EN
  logic [15:0] r_txn_count;
  logic [7:0]  r_timeout_count;

  // Response statistics: total wraps, timeouts saturate.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_txn_count     <= '0;
      r_timeout_count <= '0;
    end else if (r_state == S_RESP) begin
      r_txn_count <= r_txn_count + 16'd1;
      if (r_rsp_err && (r_timeout_count != 8'hFF)) begin
        r_timeout_count <= r_timeout_count + 8'd1;
      end
    end
  end

  assign txn_count     = r_txn_count;
  assign timeout_count = r_timeout_count;
`endif

endmodule

// File: tb/tb_user_wb_initiator.sv
// Testbench for user_wb_initiator (TIMEOUT_CYCLES=8). Acts as the Wishbone slave,
// predicts each response from the transfer rules, and checks the statistics
// counters when USER_WB_INIT_STATS_EN is defined.
module tb_user_wb_initiator;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        wb_rst_i;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_adr, cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid, rsp_err, busy;
  logic [31:0] rsp_dat;
  logic        wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_ack_i;
  logic [3:0]  wbs_sel_o;
  logic [31:0] wbs_adr_o, wbs_dat_o, wbs_dat_i;
`ifdef USER_WB_INIT_STATS_EN
  logic [15:0] txn_count;
  logic [7:0]  timeout_count;
`endif

  int checks = 0;
  int failures = 0;
  int model_txn = 0;
  int model_to = 0;
  logic [31:0] last_rsp_dat = 32'h0;

  always #5 clk = ~clk;

  user_wb_initiator #(.TIMEOUT_CYCLES(TO), .ERR_DATA(32'hDEAD_BEEF)) dut (
    .wb_clk_i(clk), .wb_rst_i(wb_rst_i),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
    .rsp_valid(rsp_valid), .rsp_dat(rsp_dat), .rsp_err(rsp_err), .busy(busy),
    .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o), .wbs_we_o(wbs_we_o),
    .wbs_sel_o(wbs_sel_o), .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o),
    .wbs_ack_i(wbs_ack_i), .wbs_dat_i(wbs_dat_i)
`ifdef USER_WB_INIT_STATS_EN
    , .txn_count(txn_count), .timeout_count(timeout_count)
`endif
  );

  // One complete transfer. Slave acks during bus cycle wait_cycles+1 (never if
  // that exceeds the timeout). Called and returns at a negedge with the DUT idle.
  task automatic run_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input int wait_cycles,
                         input logic [31:0] rdata, input bit jam_valid);
    int n;
    int exp_n;
    bit exp_err;
    bit done;
    logic [31:0] exp_dat;
    logic [31:0] exp_wdat;
    exp_n    = (wait_cycles + 1 < TO) ? wait_cycles + 1 : TO;
    exp_err  = (wait_cycles + 1 > TO);
    exp_dat  = we ? 32'h0 : (exp_err ? 32'hDEAD_BEEF : rdata);
    exp_wdat = we ? dat : 32'h0;
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL pre_ready got=%b want=1", cmd_ready);
    end
    cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
    @(negedge clk);
    // Commands presented while busy must have no effect.
    cmd_valid = jam_valid;
    cmd_we = ~we; cmd_adr = ~adr; cmd_dat = $urandom; cmd_sel = ~sel;
    n = 0;
    done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      if (!wbs_cyc_o) begin
        done = 1;
      end else begin
        n++;
        checks++;
        if ({wbs_stb_o, wbs_we_o, wbs_sel_o, wbs_adr_o, wbs_dat_o} !== {1'b1, we, sel, adr, exp_wdat}) begin
          failures++;
          $display("FAIL bus_fields cyc#%0d got stb=%b we=%b sel=%h adr=%h dat=%h want stb=1 we=%b sel=%h adr=%h dat=%h",
                   n, wbs_stb_o, wbs_we_o, wbs_sel_o, wbs_adr_o, wbs_dat_o, we, sel, adr, exp_wdat);
        end
        checks++;
        if ({rsp_valid, busy, cmd_ready} !== 3'b010) begin
          failures++;
          $display("FAIL bus_status cyc#%0d got rv/busy/rdy=%b want 010", n, {rsp_valid, busy, cmd_ready});
        end
        wbs_ack_i = (n == wait_cycles + 1);
        wbs_dat_i = wbs_ack_i ? rdata : $urandom;
        @(negedge clk);
      end
    end
    wbs_ack_i = 1'b0;
    cmd_valid = 1'b0;
    checks++;
    if (n != exp_n) begin
      failures++;
      $display("FAIL cyc_len got=%0d want=%0d", n, exp_n);
    end
    checks++;
    if ({rsp_valid, busy, cmd_ready, wbs_cyc_o} !== 4'b1100) begin
      failures++;
      $display("FAIL resp_status got rv/busy/rdy/cyc=%b want 1100", {rsp_valid, busy, cmd_ready, wbs_cyc_o});
    end
    checks++;
    if ({rsp_err, rsp_dat} !== {exp_err, exp_dat}) begin
      failures++;
      $display("FAIL resp_data got err=%b dat=%h want err=%b dat=%h", rsp_err, rsp_dat, exp_err, exp_dat);
    end
    model_txn++;
    if (exp_err && model_to < 255) model_to++;
    last_rsp_dat = exp_dat;
    @(negedge clk);
    checks++;
    if ({rsp_valid, busy, cmd_ready, rsp_dat} !== {3'b001, exp_dat}) begin
      failures++;
      $display("FAIL post_resp got rv/busy/rdy=%b dat=%h want 001 dat=%h", {rsp_valid, busy, cmd_ready}, rsp_dat, exp_dat);
    end
    $display("txn we=%0d adr=%h sel=%h wait=%0d cyc=%0d err=%0d rsp=%h", we, adr, sel, wait_cycles, n, exp_err, exp_dat);
  endtask

  task automatic test_reset;
    wb_rst_i = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0; cmd_sel = '0;
    wbs_ack_i = 1'b0; wbs_dat_i = '0;
    repeat (3) @(negedge clk);
    wb_rst_i = 1'b0;
    @(negedge clk);
    checks++;
    if ({cmd_ready, rsp_valid, rsp_err, busy, wbs_cyc_o, wbs_stb_o, wbs_we_o} !== 7'b1000000) begin
      failures++;
      $display("FAIL reset_ctrl got=%b want=1000000", {cmd_ready, rsp_valid, rsp_err, busy, wbs_cyc_o, wbs_stb_o, wbs_we_o});
    end
    checks++;
    if ({rsp_dat, wbs_adr_o, wbs_dat_o, wbs_sel_o} !== 100'h0) begin
      failures++;
      $display("FAIL reset_data got rsp=%h adr=%h dat=%h sel=%h want 0", rsp_dat, wbs_adr_o, wbs_dat_o, wbs_sel_o);
    end
    model_txn = 0; model_to = 0; last_rsp_dat = 32'h0;
  endtask

  task automatic test_write_basic;
    run_txn(1'b1, 32'h3000_0004, 32'hA5A5_1234, 4'hF, 0, 32'h0, 1'b0);
  endtask

  task automatic test_read_wait;
    run_txn(1'b0, 32'h3000_0000, 32'h0, 4'hF, 3, 32'hCAFE_F00D, 1'b1);
  endtask

  task automatic test_timeout;
    run_txn(1'b0, 32'h3000_0010, 32'h0, 4'hF, 1000, 32'h1234_5678, 1'b0);
    run_txn(1'b1, 32'h3000_0014, 32'h5555_AAAA, 4'h3, 1000, 32'h0, 1'b1);
  endtask

  task automatic test_ack_last;
    run_txn(1'b0, 32'h3000_0020, 32'h0, 4'hF, TO - 1, 32'h0BAD_F00D, 1'b0);
  endtask

  task automatic test_stray_ack;
    for (int i = 0; i < 4; i++) begin
      wbs_ack_i = 1'b1;
      wbs_dat_i = $urandom;
      @(negedge clk);
      checks++;
      if ({rsp_valid, wbs_cyc_o, cmd_ready, busy, rsp_dat} !== {4'b0010, last_rsp_dat}) begin
        failures++;
        $display("FAIL stray_ack got rv/cyc/rdy/busy=%b dat=%h want 0010 dat=%h",
                 {rsp_valid, wbs_cyc_o, cmd_ready, busy}, rsp_dat, last_rsp_dat);
      end
    end
    wbs_ack_i = 1'b0;
  endtask

  task automatic test_random;
    for (int i = 0; i < 24; i++) begin
      int w;
      w = (i % 6 == 5) ? 1000 : int'($urandom_range(0, 10));
      run_txn(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)),
              w, $urandom, 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_reset_mid;
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h3000_0040; cmd_sel = 4'hF;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (wbs_cyc_o !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_bus got cyc=%b want=1", wbs_cyc_o);
    end
    wb_rst_i = 1'b1;
    @(negedge clk);
    checks++;
    if ({wbs_cyc_o, wbs_stb_o, rsp_valid} !== 3'b000) begin
      failures++;
      $display("FAIL rst_mid_drop got cyc/stb/rv=%b want 000", {wbs_cyc_o, wbs_stb_o, rsp_valid});
    end
    wb_rst_i = 1'b0;
    model_txn = 0; model_to = 0; last_rsp_dat = 32'h0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({cmd_ready, rsp_valid, wbs_cyc_o, busy} !== 4'b1000) begin
        failures++;
        $display("FAIL rst_mid_after got rdy/rv/cyc/busy=%b want 1000", {cmd_ready, rsp_valid, wbs_cyc_o, busy});
      end
    end
    run_txn(1'b0, 32'h3000_0044, 32'h0, 4'hF, 1, 32'h7777_0001, 1'b0);
  endtask

`ifdef USER_WB_INIT_STATS_EN
  task automatic test_stats;
    test_reset();
    for (int i = 0; i < 3; i++) run_txn(1'b1, 32'h3000_0100 + 32'(i), $urandom, 4'hF, i, 32'h0, 1'b0);
    for (int i = 0; i < 2; i++) run_txn(1'b0, 32'h3000_0200, 32'h0, 4'hF, 1000, 32'h0, 1'b0);
    checks++;
    if ({txn_count, timeout_count} !== {16'(model_txn), 8'(model_to)}) begin
      failures++;
      $display("FAIL stats_small got txn=%0d to=%0d want txn=%0d to=%0d", txn_count, timeout_count, model_txn, model_to);
    end
    for (int i = 0; i < 300; i++) run_txn(1'b0, 32'h3000_0300, 32'h0, 4'hF, 1000, 32'h0, 1'b0);
    checks++;
    if ({txn_count, timeout_count} !== {16'(model_txn), 8'(model_to)}) begin
      failures++;
      $display("FAIL stats_sat got txn=%0d to=%0d want txn=%0d to=%0d", txn_count, timeout_count, model_txn, model_to);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_write_basic();
    test_read_wait();
    test_timeout();
    test_ack_last();
    test_stray_ack();
    test_random();
    test_stray_ack();
    test_reset_mid();
`ifdef USER_WB_INIT_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
